// File: rtl/mpu_matrix_loader_if.sv
// Element-stream and matrix-delivery bus for mpu_matrix_loader.
// master = producer/consumer environment, slave = the loader itself.
interface mpu_matrix_loader_if #(
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned DIM    = 5
);
  localparam int unsigned MAT_W = ELEM_W * DIM * DIM;

  logic signed [ELEM_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_last;
  logic [MAT_W-1:0]         matrix;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, matrix, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, matrix, out_valid
  );
endinterface

// File: rtl/mpu_matrix_loader.sv
// Assembles a row-major stream of signed elements into one DIMxDIM matrix and
// hands it downstream over valid/ready. Optional abort input: MPU_LOADER_ABORT_EN.
module mpu_matrix_loader #(
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned DIM    = 5,
  localparam int unsigned CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  mpu_matrix_loader_if.slave bus,
  output logic [CNT_W-1:0]   elem_count,
  output logic               frame_err,
  input  logic               err_clr
`ifdef MPU_LOADER_ABORT_EN
  ,
  input  logic               abort
`endif
);
  localparam int unsigned TOTAL = DIM * DIM;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               err_q, err_d;
  logic               wr_en;
  logic               set_err;
  logic               accept;
  logic               last_slot;
  logic               abort_req;
  logic [ELEM_W-1:0]  slot_q [TOTAL];
  logic [ELEM_W*TOTAL-1:0] matrix_flat;

`ifdef MPU_LOADER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign bus.out_valid = (state_q == FULL);
  assign bus.in_ready  = ~bus.out_valid;
  assign accept        = bus.in_valid && bus.in_ready;
  assign last_slot     = (count_q == CNT_W'(TOTAL - 1));

  // Next-state, element counter and error flag.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    set_err = 1'b0;

    unique case (state_q)
      LOAD: begin
        if (abort_req) begin
          count_d = '0;
        end else if (accept) begin
          wr_en = 1'b1;
          if (last_slot) begin
            count_d = '0;
            state_d = FULL;
            set_err = ~bus.in_last;
          end else if (bus.in_last) begin
            count_d = '0;
            set_err = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      FULL: begin
        // A drain takes priority over abort; either way the slot frees up.
        if (bus.out_ready || abort_req) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase

    if (set_err) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Element storage; slots are only ever overwritten, never cleared between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TOTAL; k++) begin
        slot_q[k] <= '0;
      end
    end else if (wr_en) begin
      slot_q[count_q] <= bus.in_data;
    end
  end

  always_comb begin
    matrix_flat = '0;
    for (int k = 0; k < TOTAL; k++) begin
      matrix_flat[ELEM_W*k +: ELEM_W] = slot_q[k];
    end
  end

  assign bus.matrix = matrix_flat;
  assign elem_count = count_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Directed self-checking bench for mpu_matrix_loader (abort cases under MPU_LOADER_ABORT_EN).
module tb_mpu_matrix_loader;
  localparam int unsigned ELEM_W = 8;
  localparam int unsigned DIM    = 5;
  localparam int unsigned TOTAL  = DIM * DIM;
  localparam int unsigned MAT_W  = ELEM_W * TOTAL;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] elem_count;
  logic       frame_err;
  logic       err_clr;
`ifdef MPU_LOADER_ABORT_EN
  logic       abort;
`endif

  int errors = 0;
  int checks = 0;

  logic [ELEM_W-1:0] vals [TOTAL];

  mpu_matrix_loader_if #(.ELEM_W(ELEM_W), .DIM(DIM)) bus ();

  mpu_matrix_loader #(.ELEM_W(ELEM_W), .DIM(DIM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .elem_count (elem_count),
    .frame_err  (frame_err),
    .err_clr    (err_clr)
`ifdef MPU_LOADER_ABORT_EN
    ,
    .abort      (abort)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [MAT_W-1:0] expect_matrix();
    logic [MAT_W-1:0] m;
    m = '0;
    for (int k = 0; k < TOTAL; k++) m[ELEM_W*k +: ELEM_W] = vals[k];
    return m;
  endfunction

  // Back-to-back stream of vals[0..n-1]; leaves signals at posedge+1.
  task automatic stream(input int n, input bit last_on_final);
    for (int i = 0; i < n; i++) begin
      bus.in_data  = vals[i];
      bus.in_last  = last_on_final && (i == n - 1);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.matrix !== '0) begin errors++; $display("FAIL reset_matrix: got %h expected 0", bus.matrix); end
    checks++; if (elem_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", elem_count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_frame();
    for (int k = 0; k < TOTAL; k++) vals[k] = 8'(k + 1);
    stream(24, 1'b0);
    checks++; if (elem_count !== 5'd24) begin errors++; $display("FAIL ff_count24: got %0d expected 24", elem_count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ff_early_valid: got %b expected 0", bus.out_valid); end
    bus.in_data  = 8'd25;
    bus.in_last  = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ff_out_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL ff_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.matrix[7:0] !== 8'd1) begin errors++; $display("FAIL ff_slot0: got %h expected 01", bus.matrix[7:0]); end
    checks++; if (bus.matrix[199:192] !== 8'd25) begin errors++; $display("FAIL ff_slot24: got %h expected 19", bus.matrix[199:192]); end
    checks++; if (bus.matrix !== expect_matrix()) begin errors++; $display("FAIL ff_matrix: got %h expected %h", bus.matrix, expect_matrix()); end
    checks++; if (elem_count !== 5'd0) begin errors++; $display("FAIL ff_count0: got %0d expected 0", elem_count); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ff_frame_err: got %b expected 0", frame_err); end
    // Producer pushes while FULL; must be ignored.
    bus.in_data  = 8'h55;
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.matrix !== expect_matrix()) begin errors++; $display("FAIL ff_hold_matrix: got %h expected %h", bus.matrix, expect_matrix()); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ff_hold_valid: got %b expected 1", bus.out_valid); end
    checks++; if (elem_count !== 5'd0) begin errors++; $display("FAIL ff_hold_count: got %0d expected 0", elem_count); end
  endtask

  task automatic test_drain();
    bus.in_data  = 8'h33;
    bus.in_valid = 1'b1;
    drain();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL dr_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL dr_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (elem_count !== 5'd0) begin errors++; $display("FAIL dr_no_accept: got %0d expected 0", elem_count); end
    checks++; if (bus.matrix[7:0] !== 8'd1) begin errors++; $display("FAIL dr_slot0_kept: got %h expected 01", bus.matrix[7:0]); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.matrix[7:0] !== 8'h33) begin errors++; $display("FAIL dr_slot0_new: got %h expected 33", bus.matrix[7:0]); end
    checks++; if (elem_count !== 5'd1) begin errors++; $display("FAIL dr_count1: got %0d expected 1", elem_count); end
    do_reset();
  endtask

  task automatic test_early_last();
    for (int k = 0; k < TOTAL; k++) vals[k] = 8'(8'hA0 + k);
    stream(10, 1'b1);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL el_frame_err: got %b expected 1", frame_err); end
    checks++; if (elem_count !== 5'd0) begin errors++; $display("FAIL el_count: got %0d expected 0", elem_count); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL el_out_valid: got %b expected 0", bus.out_valid); end
    for (int k = 0; k < TOTAL; k++) vals[k] = 8'h80;
    stream(25, 1'b1);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL el_clean_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.matrix !== expect_matrix()) begin errors++; $display("FAIL el_clean_matrix: got %h expected %h", bus.matrix, expect_matrix()); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL el_sticky: got %b expected 1", frame_err); end
    drain();
    pulse_clr();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL el_clr: got %b expected 0", frame_err); end
  endtask

  task automatic test_missing_last();
    for (int k = 0; k < TOTAL; k++) vals[k] = 8'(k * 7 + 3);
    stream(25, 1'b0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ml_out_valid: got %b expected 1", bus.out_valid); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ml_frame_err: got %b expected 1", frame_err); end
    checks++; if (bus.matrix !== expect_matrix()) begin errors++; $display("FAIL ml_matrix: got %h expected %h", bus.matrix, expect_matrix()); end
    drain();
    pulse_clr();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ml_clr: got %b expected 0", frame_err); end
  endtask

  task automatic test_err_clr_collision();
    for (int k = 0; k < TOTAL; k++) vals[k] = 8'(k);
    stream(2, 1'b0);
    bus.in_data  = 8'h7F;
    bus.in_last  = 1'b1;
    bus.in_valid = 1'b1;
    err_clr      = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    err_clr      = 1'b0;
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL col_set_wins: got %b expected 1", frame_err); end
    checks++; if (elem_count !== 5'd0) begin errors++; $display("FAIL col_count: got %0d expected 0", elem_count); end
    pulse_clr();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL col_clr: got %b expected 0", frame_err); end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < TOTAL; k++) vals[k] = 8'(8'hE0 + k);
    stream(12, 1'b0);
    checks++; if (elem_count !== 5'd12) begin errors++; $display("FAIL ar_count12: got %0d expected 12", elem_count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (elem_count !== 5'd0) begin errors++; $display("FAIL ar_count: got %0d expected 0", elem_count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.matrix !== '0) begin errors++; $display("FAIL ar_matrix: got %h expected 0", bus.matrix); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < TOTAL; k++) vals[k] = 8'(200 - k);
    stream(25, 1'b1);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ar_frame_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.matrix !== expect_matrix()) begin errors++; $display("FAIL ar_frame_matrix: got %h expected %h", bus.matrix, expect_matrix()); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ar_frame_err: got %b expected 0", frame_err); end
    drain();
  endtask

`ifdef MPU_LOADER_ABORT_EN
  task automatic test_abort();
    for (int k = 0; k < TOTAL; k++) vals[k] = 8'(k + 40);
    stream(7, 1'b0);
    checks++; if (elem_count !== 5'd7) begin errors++; $display("FAIL ab_count7: got %0d expected 7", elem_count); end
    bus.in_data  = 8'h77;
    bus.in_valid = 1'b1;
    abort        = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    abort        = 1'b0;
    checks++; if (elem_count !== 5'd0) begin errors++; $display("FAIL ab_load_count: got %0d expected 0", elem_count); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ab_load_err: got %b expected 0", frame_err); end
    stream(25, 1'b1);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ab_frame_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.matrix !== expect_matrix()) begin errors++; $display("FAIL ab_frame_matrix: got %h expected %h", bus.matrix, expect_matrix()); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ab_full_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ab_full_ready: got %b expected 1", bus.in_ready); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    err_clr       = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
`ifdef MPU_LOADER_ABORT_EN
    abort         = 1'b0;
`endif
    test_reset();
    test_full_frame();
    test_drain();
    test_early_last();
    test_missing_last();
    test_err_clr_collision();
    test_async_reset();
`ifdef MPU_LOADER_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
